// File: rtl/mvm_stream.sv
// Streaming signed ROWS x COLS matrix-vector multiplier (y = A*x) with stored-matrix reuse.
// Define MVM_SAT_EN to saturate each result to OUTPUT_WIDTH; otherwise results wrap.
module mvm_stream #(
   parameter int ROWS         = 3,
   parameter int COLS         = 3,
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           reuse_mat,
   input  logic signed [INPUT_WIDTH-1:0]  s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic signed [OUTPUT_WIDTH-1:0] m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           busy,
   output logic                           done
);
   localparam int MN    = ROWS * COLS;
   localparam int ACC_W = 2 * INPUT_WIDTH + $clog2(COLS) + 1;
   localparam int EXT_W = ((ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH) + 1;
   localparam int CW    = $clog2(MN + 1);
   localparam int XW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [CW-1:0] A_LAST   = CW'(MN - 1);
   localparam logic [CW-1:0] X_LAST   = CW'(COLS - 1);
   localparam logic [CW-1:0] MAC_END  = CW'(MN);
   localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_X  = 3'd2,
      COMPUTE = 3'd3,
      OUTPUT  = 3'd4
   } state_t;

   state_t                          state_r;
   logic [CW-1:0]                   idx_r;
   logic [XW-1:0]                   col_r;
   logic [RW-1:0]                   row_r;
   logic [RW-1:0]                   out_idx_r;
   logic                            mat_loaded_r;
   logic                            s_ready_r;
   logic                            m_valid_r;
   logic                            busy_r;
   logic                            done_r;
   logic signed [OUTPUT_WIDTH-1:0]  m_data_r;
   logic signed [ACC_W-1:0]         acc_r;
   logic signed [INPUT_WIDTH-1:0]   a_mem_r [MN];
   logic signed [INPUT_WIDTH-1:0]   x_mem_r [COLS];
   logic signed [OUTPUT_WIDTH-1:0]  y_mem_r [ROWS];

   logic signed [INPUT_WIDTH-1:0]   a_sel_s;
   logic signed [2*INPUT_WIDTH-1:0] prod_s;
   logic signed [ACC_W-1:0]         acc_sum_s;

   assign s_ready = s_ready_r;
   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign busy    = busy_r;
   assign done    = done_r;

   function automatic logic signed [OUTPUT_WIDTH-1:0] fit_out(input logic signed [ACC_W-1:0] v);
`ifdef MVM_SAT_EN
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      ext = EXT_W'(v);
      hi  = {{(EXT_W - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
      lo  = ~hi;
      if (ext > hi) begin
         fit_out = hi[OUTPUT_WIDTH-1:0];
      end else if (ext < lo) begin
         fit_out = lo[OUTPUT_WIDTH-1:0];
      end else begin
         fit_out = ext[OUTPUT_WIDTH-1:0];
      end
`else
      fit_out = OUTPUT_WIDTH'(v);
`endif
   endfunction

   // MAC datapath: current A element times current x element, added to the row accumulator
   always_comb begin
      a_sel_s = {INPUT_WIDTH{1'b0}};
      if (mat_loaded_r && (idx_r < MAC_END)) begin
         a_sel_s = a_mem_r[idx_r];
      end else begin
         a_sel_s = {INPUT_WIDTH{1'b0}};
      end
      prod_s    = a_sel_s * x_mem_r[col_r];
      acc_sum_s = acc_r + ACC_W'(prod_s);
   end

   // Transaction FSM with operand storage and registered handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         idx_r        <= {CW{1'b0}};
         col_r        <= {XW{1'b0}};
         row_r        <= {RW{1'b0}};
         out_idx_r    <= {RW{1'b0}};
         mat_loaded_r <= 1'b0;
         s_ready_r    <= 1'b0;
         m_valid_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         m_data_r     <= {OUTPUT_WIDTH{1'b0}};
         acc_r        <= {ACC_W{1'b0}};
         for (int i = 0; i < MN; i++) a_mem_r[i] <= {INPUT_WIDTH{1'b0}};
         for (int i = 0; i < COLS; i++) x_mem_r[i] <= {INPUT_WIDTH{1'b0}};
         for (int i = 0; i < ROWS; i++) y_mem_r[i] <= {OUTPUT_WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  busy_r    <= 1'b1;
                  s_ready_r <= 1'b1;
                  idx_r     <= {CW{1'b0}};
                  state_r   <= reuse_mat ? LOAD_X : LOAD_A;
               end
            end
            LOAD_A: begin
               if (s_valid && s_ready_r) begin
                  a_mem_r[idx_r] <= s_data;
                  if (idx_r == A_LAST) begin
                     idx_r        <= {CW{1'b0}};
                     mat_loaded_r <= 1'b1;
                     state_r      <= LOAD_X;
                  end else begin
                     idx_r <= idx_r + CW'(1);
                  end
               end
            end
            LOAD_X: begin
               if (s_valid && s_ready_r) begin
                  x_mem_r[idx_r[XW-1:0]] <= s_data;
                  if (idx_r == X_LAST) begin
                     s_ready_r <= 1'b0;
                     idx_r     <= {CW{1'b0}};
                     col_r     <= {XW{1'b0}};
                     row_r     <= {RW{1'b0}};
                     acc_r     <= {ACC_W{1'b0}};
                     state_r   <= COMPUTE;
                  end else begin
                     idx_r <= idx_r + CW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (idx_r == MAC_END) begin
                  m_valid_r <= 1'b1;
                  m_data_r  <= y_mem_r[0];
                  out_idx_r <= {RW{1'b0}};
                  state_r   <= OUTPUT;
               end else begin
                  idx_r <= idx_r + CW'(1);
                  if (col_r == COL_LAST) begin
                     y_mem_r[row_r] <= fit_out(acc_sum_s);
                     acc_r          <= {ACC_W{1'b0}};
                     col_r          <= {XW{1'b0}};
                     row_r          <= row_r + RW'(1);
                  end else begin
                     acc_r <= acc_sum_s;
                     col_r <= col_r + XW'(1);
                  end
               end
            end
            OUTPUT: begin
               if (m_valid_r && m_ready) begin
                  if (out_idx_r == ROW_LAST) begin
                     m_valid_r <= 1'b0;
                     done_r    <= 1'b1;
                     busy_r    <= 1'b0;
                     state_r   <= IDLE;
                  end else begin
                     out_idx_r <= out_idx_r + RW'(1);
                     m_data_r  <= y_mem_r[out_idx_r + RW'(1)];
                  end
               end
            end
            default: begin
               s_ready_r <= 1'b0;
               m_valid_r <= 1'b0;
               busy_r    <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_stream.sv
// Scoreboard bench for mvm_stream (3x3, 8-bit in, 16-bit out); honours MVM_SAT_EN for overflow expectations.
module tb_mvm_stream;
   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               reuse_mat;
   logic signed [7:0]  s_data;
   logic               s_valid;
   logic               s_ready;
   logic signed [15:0] m_data;
   logic               m_valid;
   logic               m_ready;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int words_cnt = 0;
   int exp_q[$];
   int a_v[9];
   int x_v[3];
   int y_v[3];

   mvm_stream #(.ROWS(3), .COLS(3), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .reuse_mat(reuse_mat),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake, counts done pulses and accepted words
   always @(negedge clk) begin
      if (reset) begin
         if (done) done_cnt++;
         if (s_valid && s_ready) words_cnt++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", int'(m_data), -99999);
            end else begin
               check("y_word", int'(m_data), exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input bit reuse);
      start = 1'b1;
      reuse_mat = reuse;
      step();
      start = 1'b0;
      reuse_mat = 1'b0;
   endtask

   task automatic send_word(input int d, input bit gap);
      int t;
      bit acc;
      t = 0;
      acc = 1'b0;
      s_data = 8'(d);
      s_valid = 1'b1;
      while (!acc && t < 50) begin
         @(negedge clk);
         acc = s_ready;
         step();
         t++;
      end
      s_valid = 1'b0;
      if (!acc) check("send_timeout", 0, 1);
      if (gap) step();
   endtask

   task automatic run_txn(input bit reuse, input bit gaps, input bit stall, input bit poke);
      int d0, w0, cyc, t, nw;
      d0 = done_cnt;
      w0 = words_cnt;
      nw = reuse ? 3 : 12;
      for (int i = 0; i < 3; i++) exp_q.push_back(y_v[i]);
      m_ready = !stall;
      pulse_start(reuse);
      check("busy_after_start", int'(busy), 1);
      if (!reuse) begin
         for (int i = 0; i < 9; i++) send_word(a_v[i], gaps);
      end
      for (int i = 0; i < 3; i++) send_word(x_v[i], gaps && (i < 2));
      check("s_ready_low_compute", int'(s_ready), 0);
      cyc = 0;
      while (!m_valid && cyc < 100) begin
         start = poke && (cyc == 3);
         step();
         cyc++;
      end
      start = 1'b0;
      check("latency", cyc, 10);
      check("words_accepted", words_cnt - w0, nw);
      if (stall) begin
         for (int k = 0; k < 5; k++) begin
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_m_data", int'(m_data), y_v[0]);
            check("stall_s_ready", int'(s_ready), 0);
            start = poke && (k == 2);
            step();
         end
         start = 1'b0;
         m_ready = 1'b1;
      end
      t = 0;
      while (done_cnt == d0 && t < 100) begin
         step();
         t++;
      end
      repeat (3) step();
      check("done_pulses", done_cnt - d0, 1);
      check("busy_idle", int'(busy), 0);
      check("m_valid_idle", int'(m_valid), 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      reuse_mat = 1'b0;
      s_data = 8'sd0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      #1;
      check("rst_s_ready", int'(s_ready), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      repeat (2) step();
      reset = 1'b1;
      step();

      // Basic, then same data with input gaps and output stall
      a_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      x_v = '{1, 2, 3};
      y_v = '{14, 32, 50};
      run_txn(1'b0, 1'b0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b1, 1'b1, 1'b0);

      // Reuse stored A with a new x
      x_v = '{-1, 0, 1};
      y_v = '{2, 2, 2};
      run_txn(1'b1, 1'b0, 1'b0, 1'b0);

      // Overflow, positive and negative
      a_v = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
      x_v = '{127, 127, 127};
`ifdef MVM_SAT_EN
      y_v = '{32767, 32767, 32767};
`else
      y_v = '{-17149, -17149, -17149};
`endif
      run_txn(1'b0, 1'b0, 1'b0, 1'b0);
      a_v = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
`ifdef MVM_SAT_EN
      y_v = '{-32768, -32768, -32768};
`else
      y_v = '{16768, 16768, 16768};
`endif
      run_txn(1'b0, 1'b0, 1'b0, 1'b0);

      // Start pulses during COMPUTE and OUTPUT are ignored
      a_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      x_v = '{1, 2, 3};
      y_v = '{14, 32, 50};
      run_txn(1'b0, 1'b0, 1'b1, 1'b1);

      // Reset in the middle of LOAD_X wipes the stored matrix
      pulse_start(1'b0);
      for (int i = 0; i < 9; i++) send_word(a_v[i], 1'b0);
      send_word(5, 1'b0);
      check("pre_reset_busy", int'(busy), 1);
      reset = 1'b0;
      #1;
      check("midrst_s_ready", int'(s_ready), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_m_valid", int'(m_valid), 0);
      check("midrst_m_data", int'(m_data), 0);
      check("midrst_done", int'(done), 0);
      step();
      reset = 1'b1;
      step();
      check("post_rst_idle", int'(busy), 0);
      x_v = '{5, 5, 5};
      y_v = '{0, 0, 0};
      run_txn(1'b1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
